spi_register_map: RTL and testbench

SPI_REGISTER_MAP -- requirements
Module: spi_register_map

---
 rtl/spi_register_map_pkg.sv | 12 +
 rtl/spi_slave_if.sv | 114 +++++++++++
 rtl/spi_register_map.sv | 78 +++++++
 tb/tb_spi_register_map.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_register_map_pkg.sv
// Shared constants for the SPI register map: geometry, frame layout and R/W bit encoding.
package spi_register_map_pkg;
    localparam int ADDR_WIDTH     = 7;
    localparam int DATA_WIDTH     = 8;
    localparam int NUM_CONFIG_REG = 96;
    localparam int NUM_STATUS_REG = 32;
    localparam int FRAME_WIDTH    = 16;
    localparam int CNT_WIDTH      = 5;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;
endpackage

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave front end: pin synchronizers, sck edge detect, 16-bit frame decode,
// write strobe at bit 16, read address strobe at bit 8 and the MSB-first sdo shifter.
module spi_slave_if
    import spi_register_map_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sck_i,
    input  logic                  sdi_i,
    input  logic                  cs_n_i,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic                  sdo_o
);
    localparam logic [CNT_WIDTH-1:0] CNT_ADDR_DONE  = CNT_WIDTH'(FRAME_WIDTH - DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_DATA_START = CNT_WIDTH'(FRAME_WIDTH - DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST       = CNT_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL       = CNT_WIDTH'(FRAME_WIDTH);

    logic [1:0] sck_sync_q, sdi_sync_q, cs_sync_q;
    logic       sck_prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_sync_q <= 2'b00;
            sdi_sync_q <= 2'b00;
            cs_sync_q  <= 2'b11;
            sck_prev_q <= 1'b0;
        end else begin
            sck_sync_q <= {sck_sync_q[0], sck_i};
            sdi_sync_q <= {sdi_sync_q[0], sdi_i};
            cs_sync_q  <= {cs_sync_q[0], cs_n_i};
            sck_prev_q <= sck_sync_q[1];
        end
    end

    logic sck_rise, sck_fall, cs_idle;
    assign sck_rise = sck_sync_q[1] & ~sck_prev_q;
    assign sck_fall = ~sck_sync_q[1] & sck_prev_q;
    assign cs_idle  = cs_sync_q[1];

    logic [CNT_WIDTH-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FRAME_WIDTH-2:0] shift_in_q, shift_in_d;
    logic [DATA_WIDTH-1:0]  shift_out_q, shift_out_d;
    logic                   sdo_q, sdo_d;
    logic                   is_read_q, is_read_d;
    logic [FRAME_WIDTH-1:0] shifted;

    // View of the frame including the bit being sampled on this rising edge.
    assign shifted   = {shift_in_q, sdi_sync_q[1]};
    assign wr_addr_o = shifted[FRAME_WIDTH-2:DATA_WIDTH];
    assign wr_data_o = shifted[DATA_WIDTH-1:0];
    assign rd_addr_o = shifted[ADDR_WIDTH-1:0];
    assign sdo_o     = sdo_q;

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        sdo_d       = sdo_q;
        is_read_d   = is_read_q;
        wr_en_o     = 1'b0;
        rd_en_o     = 1'b0;
        if (cs_idle) begin
            bit_cnt_d   = '0;
            shift_in_d  = '0;
            shift_out_d = '0;
            sdo_d       = 1'b0;
            is_read_d   = 1'b0;
        end else begin
            if (sck_rise && bit_cnt_q != CNT_FULL) begin
                shift_in_d = shifted[FRAME_WIDTH-2:0];
                bit_cnt_d  = bit_cnt_q + 1'b1;
                if (bit_cnt_q == CNT_ADDR_DONE && shifted[ADDR_WIDTH] == RW_READ) begin
                    rd_en_o     = 1'b1;
                    is_read_d   = 1'b1;
                    shift_out_d = rd_data_i;
                end
                if (bit_cnt_q == CNT_LAST && shifted[FRAME_WIDTH-1] == RW_WRITE) begin
                    wr_en_o = 1'b1;
                end
            end
            // Falling edges 8..15 present data bits 7..0; the final falling edge returns sdo low.
            if (sck_fall && is_read_q && bit_cnt_q >= CNT_DATA_START) begin
                if (bit_cnt_q != CNT_FULL) begin
                    sdo_d       = shift_out_q[DATA_WIDTH-1];
                    shift_out_d = {shift_out_q[DATA_WIDTH-2:0], 1'b0};
                end else begin
                    sdo_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bit_cnt_q   <= '0;
            shift_in_q  <= '0;
            shift_out_q <= '0;
            sdo_q       <= 1'b0;
            is_read_q   <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            sdo_q       <= sdo_d;
            is_read_q   <= is_read_d;
        end
    end
endmodule

// File: rtl/spi_register_map.sv
// SPI-accessible register map: 96 read/write config registers followed by 32 read-only
// status addresses mirroring two synchronized status pins; config register 0 drives uo_out.
module spi_register_map #(
    parameter int ADDR_WIDTH     = spi_register_map_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH     = spi_register_map_pkg::DATA_WIDTH,
    parameter int NUM_CONFIG_REG = spi_register_map_pkg::NUM_CONFIG_REG,
    parameter int NUM_STATUS_REG = spi_register_map_pkg::NUM_STATUS_REG
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    import spi_register_map_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] CFG_END      = ADDR_WIDTH'(NUM_CONFIG_REG);
    localparam logic [ADDR_WIDTH-1:0] STAT_HI_BASE = ADDR_WIDTH'(NUM_CONFIG_REG + NUM_STATUS_REG / 2);

    logic                  wr_en, rd_en, sdo;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
    logic [DATA_WIDTH-1:0] wr_data, rd_data;
    logic [DATA_WIDTH-1:0] config_q [NUM_CONFIG_REG];
    logic [1:0]            stat_lo_q, stat_hi_q;

    spi_slave_if u_spi (
        .clk_i     (clk),
        .rst_i     (rst),
        .sck_i     (uio_in[0]),
        .sdi_i     (uio_in[1]),
        .cs_n_i    (uio_in[3]),
        .wr_en_o   (wr_en),
        .wr_addr_o (wr_addr),
        .wr_data_o (wr_data),
        .rd_en_o   (rd_en),
        .rd_addr_o (rd_addr),
        .rd_data_i (rd_data),
        .sdo_o     (sdo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_lo_q <= 2'b00;
            stat_hi_q <= 2'b00;
        end else begin
            stat_lo_q <= {stat_lo_q[0], uio_in[5]};
            stat_hi_q <= {stat_hi_q[0], uio_in[4]};
        end
    end

    // Writes into the status range fall outside the array and are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CONFIG_REG; i++) config_q[i] <= '0;
        end else if (wr_en && wr_addr < CFG_END) begin
            config_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_en) begin
            if (rd_addr < CFG_END)           rd_data = config_q[rd_addr];
            else if (rd_addr < STAT_HI_BASE) rd_data = {DATA_WIDTH{stat_lo_q[1]}};
            else                             rd_data = {DATA_WIDTH{stat_hi_q[1]}};
        end
    end

    assign uo_out  = config_q[0];
    assign uio_out = {5'b00000, sdo, 2'b00};
    assign uio_oe  = 8'b0000_0100;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, ui_in, uio_in[7:6], uio_in[2]};
endmodule

// File: tb/tb_spi_register_map.sv
// Randomized scoreboard bench for spi_register_map: SPI master driver, sdo monitor,
// register-map reference model and expected-read queue.
module tb_spi_register_map;
  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic       sck = 1'b0, sdi = 1'b0, cs_n = 1'b1, st_hi = 1'b0, st_lo = 1'b0;
  logic [7:0] uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic       sdo;

  assign uio_in = {2'b00, st_lo, st_hi, cs_n, 1'b0, sdi, sck};
  assign sdo    = uio_out[2];

  spi_register_map dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // clock / reset
  always #50 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] cfg_model[96];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: config array plus status pins
  function automatic logic [7:0] model_read(input int addr);
    if (addr < 96) return cfg_model[addr];
    else if (addr < 112) return {8{st_lo}};
    else return {8{st_hi}};
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // driver: one SPI frame with n_rise sck pulses (< 16 aborts, > 16 adds extra edges)
  task automatic spi_frame(input logic rw, input int addr, input logic [7:0] data, input int n_rise);
    logic [15:0] f;
    f = {rw, 7'(addr), data};
    if (n_rise >= 16) begin
      if (rw) exp_q.push_back(model_read(addr));
      else if (addr < 96) cfg_model[addr] = data;
    end
    cs_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < n_rise; i++) begin
      sdi = (i < 16) ? f[15-i] : 1'b0;
      wait_clk(HALF);
      sck = 1'b1;
      wait_clk(HALF);
      sck = 1'b0;
    end
    wait_clk(HALF);
    cs_n = 1'b1;
    sdi  = 1'b0;
    wait_clk(2 * HALF);
  endtask

  // monitor: reassembles each frame from the pins and checks sdo against the queue
  int         rises;
  logic [15:0] frm;
  logic [7:0]  rd_bits;
  logic        hdr;
  initial begin
    forever begin
      @(negedge cs_n);
      rises = 0; frm = '0; rd_bits = '0; hdr = 1'b0;
      while (cs_n === 1'b0) begin
        @(posedge sck or posedge cs_n);
        if (cs_n === 1'b0) begin
          if (rises < 16) begin
            frm[15-rises] = sdi;
            if (rises < 8) hdr = hdr | sdo;
            else rd_bits[15-rises] = sdo;
          end
          rises++;
        end
      end
      if (rises >= 16) begin
        check("sdo_header_zero", {7'b0, hdr}, 8'h00);
        if (frm[15]) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL read_unexpected: got %02h, expected no read", rd_bits);
          end else begin
            check($sformatf("read_addr_%02h", frm[14:8]), rd_bits, exp_q.pop_front());
          end
        end else begin
          check("sdo_write_frame_zero", rd_bits, 8'h00);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "timeout");
  end

  int   addrs[8];
  bit   used[96];
  int   a;
  logic [7:0] d;

  initial begin
    for (int i = 0; i < 96; i++) cfg_model[i] = 8'h00;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(5);
    check("reset_uo_out", uo_out, 8'h00);
    check("uio_oe_const", uio_oe, 8'h04);
    check("uio_out_idle", uio_out, 8'h00);

    spi_frame(1'b1, 0, 8'h00, 16);
    spi_frame(1'b0, 8'h05, 8'hA7, 16);
    spi_frame(1'b1, 8'h05, 8'h00, 16);
    spi_frame(1'b0, 8'h00, 8'h3C, 16);
    check("uo_out_cfg0", uo_out, 8'h3C);

    st_lo = 1'b0; st_hi = 1'b1;
    wait_clk(4);
    spi_frame(1'b1, 8'h60, 8'h00, 16);
    spi_frame(1'b1, 8'h6F, 8'h00, 16);
    spi_frame(1'b1, 8'h70, 8'h00, 16);
    spi_frame(1'b1, 8'h7F, 8'h00, 16);
    spi_frame(1'b0, 8'h70, 8'h12, 16);
    spi_frame(1'b1, 8'h70, 8'h00, 16);
    st_lo = 1'b1; st_hi = 1'b0;
    wait_clk(4);
    spi_frame(1'b1, 8'h65, 8'h00, 16);
    spi_frame(1'b1, 8'h75, 8'h00, 16);

    // distinct random addresses, then overwrites, then read back
    for (int i = 0; i < 8; i++) begin
      do a = $urandom_range(0, 95); while (used[a]);
      used[a] = 1'b1;
      addrs[i] = a;
      spi_frame(1'b0, a, 8'($urandom), 16);
    end
    for (int i = 0; i < 3; i++) spi_frame(1'b0, addrs[$urandom_range(0, 7)], 8'($urandom), 16);
    for (int i = 0; i < 8; i++) spi_frame(1'b1, addrs[i], 8'h00, 16);

    // frame with extra sck edges still writes once, extras ignored
    spi_frame(1'b0, 8'h20, 8'h9B, 18);
    spi_frame(1'b1, 8'h20, 8'h00, 16);

    // aborted write leaves the prior value
    spi_frame(1'b0, 8'h10, 8'h3A, 16);
    spi_frame(1'b0, 8'h10, 8'h55, 12);
    spi_frame(1'b1, 8'h10, 8'h00, 16);
    spi_frame(1'b1, 8'h05, 8'h00, 12);

    // random mixed traffic across the whole address space
    for (int i = 0; i < 16; i++) begin
      a = $urandom_range(0, 127);
      d = 8'($urandom);
      spi_frame(1'($urandom_range(0, 1)), a, d, 16);
    end

    // reset mid-frame clears every config register
    cs_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 6; i++) begin
      sdi = 1'($urandom);
      wait_clk(HALF); sck = 1'b1;
      wait_clk(HALF); sck = 1'b0;
    end
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    for (int i = 0; i < 96; i++) cfg_model[i] = 8'h00;
    wait_clk(HALF);
    cs_n = 1'b1;
    wait_clk(2 * HALF);
    check("uo_out_after_rst", uo_out, 8'h00);
    spi_frame(1'b1, 8'h00, 8'h00, 16);
    spi_frame(1'b1, 8'h05, 8'h00, 16);
    spi_frame(1'b1, 8'h10, 8'h00, 16);
    for (int i = 0; i < 8; i++) spi_frame(1'b1, addrs[i], 8'h00, 16);
    spi_frame(1'b0, 8'h2A, 8'hC3, 16);
    spi_frame(1'b1, 8'h2A, 8'h00, 16);

    wait_clk(20);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_reads: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
